// File: rtl/prog_ram_clk.sv
// Clock-enable generator (divide-by-DIVISOR) plus a single-port, write-first RAM,
// all on one system clock with an asynchronous active-low reset.
module prog_ram_clk #(
    parameter int DIVISOR    = 10,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sysclk,
    input  logic                  reset,
    output logic                  clken,
    output logic                  clken2,
    output logic                  slowclk,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam int HALF  = DIVISOR / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(HALF);

    generate
        if ((DIVISOR < 2) || (DIVISOR % 2 != 0)) begin : g_bad_divisor
            $error("prog_ram_clk: DIVISOR must be even and >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Divider: enables and slow clock are pure decodes of the counter
    // register, so they are glitch-free and change only on sysclk edges.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clken   = (cnt_q == CNT_LAST);
    assign clken2  = (cnt_q == CNT_MID);
    assign slowclk = (cnt_q >= CNT_HIGH);

    // ------------------------------------------------------------------
    // RAM: free-running on sysclk, not gated by clken.
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch on purpose: contents survive reset,
    // and the declaration initialiser provides the all-zero power-up image.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge sysclk) begin
        if (reset && rw) begin
            mem_q[addr] <= data_in;
        end
    end

    // Read port is write-first: a write edge returns the new data.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (rw) begin
            data_q <= data_in;
        end else begin
            data_q <= mem_q[addr];
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_prog_ram_clk.sv
// Directed bench for prog_ram_clk: enable timing, write-first RAM, async reset.
module tb_prog_ram_clk;

    localparam int DIV = 10;
    localparam int AW  = 4;
    localparam int DW  = 8;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          clken;
    logic          clken2;
    logic          slowclk;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    int checks = 0;
    int errors = 0;

    prog_ram_clk #(
        .DIVISOR    (DIV),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .clken    (clken),
        .clken2   (clken2),
        .slowclk  (slowclk),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 sysclk = ~sysclk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        rw      = 1'b0;
        addr    = '0;
        data_in = '0;
        repeat (2) @(negedge sysclk);
        checks++;
        if (clken !== 1'b0) begin
            errors++; $display("FAIL reset_clken got %b exp 0", clken);
        end
        checks++;
        if (clken2 !== 1'b0) begin
            errors++; $display("FAIL reset_clken2 got %b exp 0", clken2);
        end
        checks++;
        if (slowclk !== 1'b0) begin
            errors++; $display("FAIL reset_slowclk got %b exp 0", slowclk);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data_out got %h exp 00", data_out);
        end
        reset = 1'b1;
    endtask

    // Edge n after release leaves cnt = n mod DIV.
    task automatic test_clken_timing();
        for (int n = 1; n <= 25; n++) begin
            tick();
            checks++;
            if (clken !== ((n % DIV) == DIV - 1)) begin
                errors++; $display("FAIL clken_edge%0d got %b exp %b", n, clken, (n % DIV) == DIV - 1);
            end
            checks++;
            if (clken2 !== ((n % DIV) == DIV / 2 - 1)) begin
                errors++; $display("FAIL clken2_edge%0d got %b exp %b", n, clken2, (n % DIV) == DIV / 2 - 1);
            end
            checks++;
            if (slowclk !== ((n % DIV) >= DIV / 2)) begin
                errors++; $display("FAIL slowclk_edge%0d got %b exp %b", n, slowclk, (n % DIV) >= DIV / 2);
            end
            if (n == 1) begin
                checks++;
                if (data_out !== 8'h00) begin
                    errors++; $display("FAIL powerup_mem0 got %h exp 00", data_out);
                end
            end
        end
    endtask

    task automatic test_write_read();
        addr    = 4'd1;
        data_in = 8'hFF;
        rw      = 1'b1;
        tick();
        checks++;
        if (data_out !== 8'hFF) begin
            errors++; $display("FAIL write_first got %h exp FF", data_out);
        end
        rw      = 1'b0;
        data_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data_out !== 8'hFF) begin
                errors++; $display("FAIL read_hold%0d got %h exp FF", i, data_out);
            end
        end
        addr = 4'd2;
        tick();
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL read_addr2 got %h exp 00", data_out);
        end
        addr = 4'd1;
        tick();
        checks++;
        if (data_out !== 8'hFF) begin
            errors++; $display("FAIL reread_addr1 got %h exp FF", data_out);
        end
    endtask

    task automatic test_reset_mid();
        int  i;
        bit  seen;
        seen = 1'b0;
        for (i = 0; i < 2 * DIV; i++) begin
            if (clken === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL wait_clken got timeout exp pulse within %0d cycles", 2 * DIV);
        end
        repeat (7) tick();
        checks++;
        if (slowclk !== 1'b1 || data_out !== 8'hFF) begin
            errors++; $display("FAIL pre_reset_cnt6 got slowclk=%b data=%h exp 1/FF", slowclk, data_out);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (clken !== 1'b0 || clken2 !== 1'b0 || slowclk !== 1'b0) begin
            errors++; $display("FAIL async_reset_enables got %b%b%b exp 000", clken, clken2, slowclk);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL async_reset_data got %h exp 00", data_out);
        end
        // Writes attempted during reset must be dropped.
        rw      = 1'b1;
        data_in = 8'h33;
        @(negedge sysclk);
        tick();
        checks++;
        if (slowclk !== 1'b0 || data_out !== 8'h00) begin
            errors++; $display("FAIL held_in_reset got slowclk=%b data=%h exp 0/00", slowclk, data_out);
        end
        rw    = 1'b0;
        reset = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (clken !== ((n % DIV) == DIV - 1)) begin
                errors++; $display("FAIL restart_clken_edge%0d got %b exp %b", n, clken, (n % DIV) == DIV - 1);
            end
            if (n == 1) begin
                checks++;
                if (data_out !== 8'hFF) begin
                    errors++; $display("FAIL mem_kept_over_reset got %h exp FF", data_out);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] val;
        addr = 4'd1;
        rw   = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i == 0)       val = 8'hFF;
            else if (i == 79) val = 8'h5A;
            else              val = 8'(i * 37 + 3);
            data_in = val;
            tick();
            checks++;
            if (data_out !== val) begin
                errors++; $display("FAIL b2b_write%0d got %h exp %h", i, data_out, val);
            end
        end
        rw      = 1'b0;
        data_in = 8'h00;
        tick();
        checks++;
        if (data_out !== 8'h5A) begin
            errors++; $display("FAIL b2b_final got %h exp 5A", data_out);
        end
    endtask

    task automatic test_all_addresses();
        rw = 1'b1;
        for (int a = 0; a < 16; a++) begin
            addr    = 4'(a);
            data_in = 8'(a) ^ 8'hA5;
            tick();
        end
        rw      = 1'b0;
        data_in = 8'h00;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            tick();
            checks++;
            if (data_out !== (8'(a) ^ 8'hA5)) begin
                errors++; $display("FAIL readback_addr%0d got %h exp %h", a, data_out, 8'(a) ^ 8'hA5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clken_timing();
        test_write_read();
        test_reset_mid();
        test_back_to_back();
        test_all_addresses();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
